// File: rtl/pulse_bank.sv
// pulse_bank: bank of independent programmable pulse/toggle/oneshot
// generators sharing one enable, one sync strobe and one config port.
// Ports: clk, rst (sync, active-high), ena, sync, cfg_wr, cfg_ch,
//   cfg_ticks, cfg_mode -> out[CHANNELS], active[CHANNELS].
module pulse_bank #(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  localparam int W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [W-1:0]        cfg_ch,
  input  logic [N-1:0]        cfg_ticks,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] active
);

  typedef enum logic [1:0] {
    M_OFF     = 2'b00,
    M_PULSE   = 2'b01,
    M_TOGGLE  = 2'b10,
    M_ONESHOT = 2'b11
  } mode_t;

  logic [N-1:0] ticks   [CHANNELS];
  mode_t        mode    [CHANNELS];
  logic [N-1:0] cnt     [CHANNELS];
  logic         armed   [CHANNELS];

  logic [N-1:0] ticks_n [CHANNELS];
  mode_t        mode_n  [CHANNELS];
  logic [N-1:0] cnt_n   [CHANNELS];
  logic         armed_n [CHANNELS];
  logic [CHANNELS-1:0] out_n;
  logic [CHANNELS-1:0] active_n;

  logic [31:0] ch_idx;
  assign ch_idx = 32'(cfg_ch);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      logic run;
      logic ev;
      ticks_n[i] = ticks[i];
      mode_n[i]  = mode[i];
      cnt_n[i]   = cnt[i];
      armed_n[i] = armed[i];
      out_n[i]   = 1'b0;
      run        = 1'b0;
      ev         = 1'b0;
      if (cfg_wr && ch_idx == 32'(i)) begin
        ticks_n[i] = cfg_ticks;
        mode_n[i]  = mode_t'(cfg_mode);
        cnt_n[i]   = '0;
        armed_n[i] = 1'b1;
      end else if (sync) begin
        cnt_n[i]   = '0;
        armed_n[i] = 1'b1;
      end else if (mode[i] == M_OFF) begin
        cnt_n[i]   = '0;
      end else begin
        run = ena && armed[i];
        // >= rather than == so a stale cnt above ticks recovers at once
        ev  = run && (cnt[i] >= ticks[i]);
        if (run)
          cnt_n[i] = ev ? '0 : cnt[i] + 1'b1;
        unique case (mode[i])
          M_PULSE:   out_n[i] = ev;
          M_TOGGLE:  out_n[i] = ev ? ~out[i] : out[i];
          M_ONESHOT: begin
            out_n[i] = ev;
            if (ev)
              armed_n[i] = 1'b0;
          end
          default:   out_n[i] = 1'b0;
        endcase
      end
      active_n[i] = (mode_n[i] != M_OFF) && armed_n[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ticks[i] <= '0;
        mode[i]  <= M_OFF;
        cnt[i]   <= '0;
        armed[i] <= 1'b0;
      end
      out    <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ticks[i] <= ticks_n[i];
        mode[i]  <= mode_n[i];
        cnt[i]   <= cnt_n[i];
        armed[i] <= armed_n[i];
      end
      out    <= out_n;
      active <= active_n;
    end
  end

endmodule

// File: tb/tb_pulse_bank.sv
// tb_pulse_bank: randomized and directed checks of pulse_bank
// against an event-counting reference model.
module tb_pulse_bank;
  localparam int N = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst, ena, sync, cfg_wr;
  logic [1:0] cfg_ch, cfg_mode;
  logic [N-1:0] cfg_ticks;
  logic [C-1:0] out, active;

  always #5 clk = ~clk;

  pulse_bank #(.N(N), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sync(sync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_ticks(cfg_ticks),
    .cfg_mode(cfg_mode), .out(out), .active(active)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: per channel, count enabled running cycles since (re)start
  // and events seen; an event lands on every (ticks+1)-th such cycle.
  int m_ticks [C];
  int m_mode  [C];
  int m_e     [C];
  int m_nev   [C];
  bit m_ev    [C];

  task automatic model_step();
    for (int i = 0; i < C; i++) begin
      bit running;
      if (rst) begin
        m_ticks[i] = 0; m_mode[i] = 0;
        m_e[i] = 0; m_nev[i] = 0; m_ev[i] = 0;
      end else if (cfg_wr && int'(cfg_ch) == i) begin
        m_ticks[i] = int'(cfg_ticks); m_mode[i] = int'(cfg_mode);
        m_e[i] = 0; m_nev[i] = 0; m_ev[i] = 0;
      end else if (sync) begin
        m_e[i] = 0; m_nev[i] = 0; m_ev[i] = 0;
      end else begin
        m_ev[i] = 0;
        running = ena && m_mode[i] != 0 &&
                  !(m_mode[i] == 3 && m_nev[i] > 0);
        if (running) begin
          if (m_e[i] % (m_ticks[i] + 1) == m_ticks[i]) begin
            m_nev[i]++;
            m_ev[i] = 1;
          end
          m_e[i]++;
        end
      end
    end
  endtask

  function automatic logic [C-1:0] exp_out();
    logic [C-1:0] r = '0;
    for (int i = 0; i < C; i++)
      case (m_mode[i])
        1, 3:    r[i] = m_ev[i];
        2:       r[i] = m_nev[i][0];
        default: r[i] = 1'b0;
      endcase
    return r;
  endfunction

  function automatic logic [C-1:0] exp_act();
    logic [C-1:0] r = '0;
    for (int i = 0; i < C; i++)
      r[i] = m_mode[i] != 0 && !(m_mode[i] == 3 && m_nev[i] > 0);
    return r;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit s,
                     input bit w, input int ch, input int md,
                     input int tk);
    rst = r; ena = e; sync = s; cfg_wr = w;
    cfg_ch = 2'(ch); cfg_mode = 2'(md); cfg_ticks = 8'(tk);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 0, 1, 0);
    vectors++;
    if (out !== 4'b0 || active !== 4'b0) begin
      errors++;
      $display("FAIL reset out=%b act=%b want 0000/0000", out, active);
    end
  endtask

  task automatic test_pulse();
    do_reset();
    cyc(0, 1, 0, 1, 0, 1, 3);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) idle();
      vectors++;
      if (out[0] !== (c >= 5 && (c - 5) % 4 == 0) || active[0] !== 1'b1) begin
        errors++;
        $display("FAIL pulse c=%0d out0=%b act0=%b", c, out[0], active[0]);
      end
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL pulse_model c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  task automatic test_toggle();
    do_reset();
    cyc(0, 1, 0, 1, 1, 2, 1);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) idle();
      vectors++;
      if (out[1] !== (c >= 3 && ((c - 3) / 2) % 2 == 0)) begin
        errors++;
        $display("FAIL toggle c=%0d out1=%b", c, out[1]);
      end
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL toggle_model c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  task automatic test_oneshot_sync();
    do_reset();
    cyc(0, 1, 0, 1, 2, 3, 2);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) cyc(0, 1, (c - 1 == 10), 0, 0, 0, 0);
      vectors++;
      if (out[2] !== (c == 4 || c == 14) ||
          active[2] !== !((c >= 4 && c <= 10) || c >= 14)) begin
        errors++;
        $display("FAIL oneshot c=%0d out2=%b act2=%b", c, out[2], active[2]);
      end
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL oneshot_model c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  task automatic test_ena_gap();
    do_reset();
    cyc(0, 1, 0, 1, 1, 2, 0);
    cyc(0, 1, 0, 1, 0, 1, 3);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) cyc(0, !(c - 1 >= 3 && c - 1 <= 6), 0, 0, 0, 0, 0);
      vectors++;
      if (out[0] !== (c == 9 || c == 13)) begin
        errors++;
        $display("FAIL ena_gap c=%0d out0=%b", c, out[0]);
      end
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL ena_gap_model c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(0, 1, 0, 1, 3, 1, 0);
    cyc(0, 1, 0, 1, 0, 1, 3);
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) cyc(0, 1, 0, (c - 1 == 4), 0, 1, 5);
      vectors++;
      if (out[0] !== (c == 11 || c == 17 || c == 23) || out[3] !== 1'b1) begin
        errors++;
        $display("FAIL cfg_collide c=%0d out0=%b out3=%b", c, out[0], out[3]);
      end
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL cfg_collide_model c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(0, 1, 0, 1, 1, 2, 1);
    cyc(0, 1, 0, 1, 2, 3, 6);
    cyc(0, 1, 0, 1, 3, 1, 0);
    cyc(0, 1, 0, 1, 0, 1, 3);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) cyc((c - 1 == 7), 1, 0, 0, 0, 0, 0);
      if (c >= 8) begin
        vectors++;
        if (out !== 4'b0 || active !== 4'b0) begin
          errors++;
          $display("FAIL reset_mid c=%0d out=%b act=%b", c, out, active);
        end
      end
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL reset_mid_model c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit r, e, s, w;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 29) == 0);
      w = ($urandom_range(0, 9) == 0);
      cyc(r, e, s, w, $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                      : $urandom_range(0, 6));
      vectors++;
      if (out !== exp_out() || active !== exp_act()) begin
        errors++;
        $display("FAIL random c=%0d out=%b/%b act=%b/%b",
                 c, out, exp_out(), active, exp_act());
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_ticks = '0;
    test_reset();
    test_pulse();
    test_toggle();
    test_oneshot_sync();
    test_ena_gap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pulse_bank.md
PULSE_BANK -- requirements
Module: pulse_bank

Interface
- REQ-001: Parameter N, default 8: per-channel counter and period width.
- REQ-002: Parameter CHANNELS, default 4: number of independent generator channels, minimum 1.
- REQ-003: clk  input  1  single clock; all state updates on posedge clk.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: ena  input  1  global count enable; low freezes all counters.
- REQ-006: sync  input  1  one-cycle strobe restarting all channels in phase.
- REQ-007: cfg_wr  input  1  configuration write strobe.
- REQ-008: cfg_ch  input  $clog2(CHANNELS) (min 1)  target channel of cfg_wr.
- REQ-009: cfg_ticks  input  N  period value for target channel.
- REQ-010: cfg_mode  input  2  mode for target channel: 00 OFF, 01 PULSE, 10 TOGGLE, 11 ONESHOT.
- REQ-011: out  output  CHANNELS  registered per-channel generator outputs.
- REQ-012: active  output  CHANNELS  registered; bit high when channel mode is not OFF and channel is armed.

Function
- REQ-013: Each channel SHALL hold ticks[N-1:0], mode[1:0], cnt[N-1:0], armed, out.
- REQ-014: Counting: on a cycle with ena=1 and channel active, if cnt >= ticks then cnt <= 0 and an event fires, else cnt <= cnt+1; the event period is ticks+1 enabled cycles.
- REQ-015: Comparison SHALL be unsigned >= so cnt above ticks can never run away; no wrap of cnt past 2^N-1 is possible.
- REQ-016: ticks=0: event fires on every enabled cycle.
- REQ-017: PULSE: out <= 1 in the cycle after an event, out <= 0 on every other cycle (including ena=0 cycles); ticks=0 gives out held high while ena=1.
- REQ-018: TOGGLE: out <= ~out on each event; out holds its level otherwise, including while ena=0.
- REQ-019: ONESHOT: first event sets out <= 1 for exactly one cycle and clears armed; channel then stops counting, out=0, active=0 until re-armed by cfg_wr or sync.
- REQ-020: OFF: cnt held 0, out=0, active=0.
- REQ-021: ena=0: cnt, armed, TOGGLE out frozen; no events fire.
- REQ-022: cfg_wr: in the following cycle channel cfg_ch has ticks=cfg_ticks, mode=cfg_mode, cnt=0, out=0, armed=1; latency one cycle.
- REQ-023: cfg_ch >= CHANNELS: write ignored, no state changes.
- REQ-024: sync: every channel gets cnt=0, out=0, armed=1 next cycle; ticks and mode unchanged; takes effect regardless of ena.
- REQ-025: Precedence per channel, highest first: rst, cfg_wr to that channel, sync, event/count; a suppressed event produces no pulse and no toggle.
- REQ-026: cfg_wr and sync in same cycle: addressed channel takes the new config, all others are synced.
- REQ-027: Channels SHALL be fully independent apart from shared ena, sync, and cfg port.

Reset
- REQ-028: rst=1 SHALL set for all channels: out=0, active=0, cnt=0, ticks=0, mode=OFF, armed=0, one cycle after sampling, overriding all other inputs.
- REQ-029: rst asserted mid-operation SHALL abort all counting; no pulse or toggle appears in the cycle after rst.

Verification (N=8, CHANNELS=4, ena=1 unless stated; cfg_wr in cycle 0)
- REQ-030: PULSE ch0 ticks=3 -> out[0]=1 only in cycles 5, 9, 13, ...; active[0]=1 from cycle 1.
- REQ-031: TOGGLE ch1 ticks=1 -> out[1] rises cycle 3, falls cycle 5, rises cycle 7 (period 4 square wave).
- REQ-032: ONESHOT ch2 ticks=2 -> out[2]=1 in cycle 4 only, active[2]=0 from cycle 4; sync in cycle 10 -> next pulse in cycle 14.
- REQ-033: PULSE ch0 ticks=3, ena=0 during cycles 3-6 -> out[0]=0 throughout; first pulse in cycle 9; TOGGLE channels hold level across the gap.
- REQ-034: cfg_wr to ch0 (ticks=5) coincident with an event -> no pulse the next cycle; pulses resume every 6 cycles. PULSE ticks=0 -> out continuously 1.
- REQ-035: rst in cycle 7 with all four channels running -> cycle 8 all out=0, active=0; no output activity until a new cfg_wr.
